uart_tx_axi_fifo: RTL and testbench

AXI4-lite slave that feeds the UART_T transmitter through a parametrised byte FIFO. It generalises the single-byte write bridge: it accepts full-width writes with byte strobes and unpacks every enabled lane into the FIFO. It also exposes a readable status register. It sits between the CPU bus interconnect and uart_t, decoupling bus writes from serial line rate.

---
 rtl/uart_tx_axi_fifo.sv | 215 +++++++++++++++++++++
 tb/tb_uart_tx_axi_fifo.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_axi_fifo.sv
// AXI4-lite slave that unpacks strobed write lanes into a byte FIFO feeding uart_t.
// Also exposes a read-only STATUS register with FIFO occupancy and write-FSM activity.
module uart_tx_axi_fifo #(
    parameter int DATA_W     = 32,
    parameter int FIFO_DEPTH = 16,
    parameter int ADDR_W     = 32
) (
    input  logic                clk,
    input  logic                rstn,
    output logic [7:0]          data,
    output logic                valid,
    input  logic                ready,
    input  logic [ADDR_W-1:0]   awaddr,
    input  logic                awvalid,
    output logic                awready,
    input  logic [DATA_W-1:0]   wdata,
    input  logic [DATA_W/8-1:0] wstrb,
    input  logic                wvalid,
    output logic                wready,
    output logic                bvalid,
    input  logic                bready,
    output logic [1:0]          bresp,
    input  logic [ADDR_W-1:0]   araddr,
    input  logic                arvalid,
    output logic                arready,
    output logic [DATA_W-1:0]   rdata,
    output logic                rvalid,
    input  logic                rready,
    output logic [1:0]          rresp
);
    localparam int NB = DATA_W / 8;
    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam logic [CW-1:0] DEPTH_C     = CW'(FIFO_DEPTH);
    localparam logic [1:0]    RESP_OKAY   = 2'b00;
    localparam logic [1:0]    RESP_SLVERR = 2'b10;
    localparam logic [1:0]    REG_TXDATA  = 2'd0;
    localparam logic [1:0]    REG_STATUS  = 2'd1;

    typedef enum logic [1:0] {W_IDLE, W_PUSH, W_RESP} wstate_e;
    typedef enum logic       {R_IDLE, R_DATA} rstate_e;

    wstate_e           wstate_q, wstate_d;
    rstate_e           rstate_q, rstate_d;
    logic              aw_held_q, aw_held_d;
    logic [1:0]        aw_reg_q, aw_reg_d;
    logic              w_held_q, w_held_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [NB-1:0]     wstrb_q, wstrb_d;
    logic [1:0]        bresp_q, bresp_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic [1:0]        rresp_q, rresp_d;
    logic [7:0]        mem_q [FIFO_DEPTH];
    logic [PW-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]     count_q, count_d;

    logic              push, pop, lane_found;
    logic [7:0]        push_byte;
    logic [NB-1:0]     strb_left;
    logic [DATA_W-1:0] status;
    logic              unused_addr;

    assign unused_addr = ^{awaddr[ADDR_W-1:4], awaddr[1:0], araddr[ADDR_W-1:4], araddr[1:0]};

    // Lowest remaining enabled lane, so lanes always leave in ascending order.
    always_comb begin
        push_byte  = '0;
        strb_left  = wstrb_q;
        lane_found = 1'b0;
        for (int unsigned i = 0; i < NB; i++) begin
            if (wstrb_q[i] && !lane_found) begin
                lane_found   = 1'b1;
                push_byte    = wdata_q[8*i +: 8];
                strb_left[i] = 1'b0;
            end
        end
    end

    assign push = (wstate_q == W_PUSH) && (count_q != DEPTH_C);
    assign pop  = (count_q != '0) && ready;

    always_comb begin
        wr_ptr_d = push ? wr_ptr_q + PW'(1) : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + PW'(1) : rd_ptr_q;
        case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_comb begin
        wstate_d  = wstate_q;
        aw_held_d = aw_held_q;
        aw_reg_d  = aw_reg_q;
        w_held_d  = w_held_q;
        wdata_d   = wdata_q;
        wstrb_d   = wstrb_q;
        bresp_d   = bresp_q;
        if (awvalid && !aw_held_q) begin
            aw_held_d = 1'b1;
            aw_reg_d  = awaddr[3:2];
        end
        if (wvalid && !w_held_q) begin
            w_held_d = 1'b1;
            wdata_d  = wdata;
            wstrb_d  = wstrb;
        end
        case (wstate_q)
            W_IDLE: begin
                if (aw_held_q && w_held_q) begin
                    if (aw_reg_q != REG_TXDATA) begin
                        wstate_d = W_RESP;
                        bresp_d  = RESP_SLVERR;
                    end else if (wstrb_q != '0) begin
                        wstate_d = W_PUSH;
                    end else begin
                        wstate_d = W_RESP;
                        bresp_d  = RESP_OKAY;
                    end
                end
            end
            W_PUSH: begin
                if (push) begin
                    wstrb_d = strb_left;
                    if (strb_left == '0) begin
                        wstate_d = W_RESP;
                        bresp_d  = RESP_OKAY;
                    end
                end
            end
            W_RESP: begin
                if (bready) begin
                    wstate_d  = W_IDLE;
                    aw_held_d = 1'b0;
                    w_held_d  = 1'b0;
                end
            end
            default: wstate_d = W_IDLE;
        endcase
    end

    always_comb begin
        status             = '0;
        status[CW-1:0]     = count_q;
        status[16]         = (count_q == '0);
        status[17]         = (count_q == DEPTH_C);
        status[18]         = (wstate_q != W_IDLE);
        rstate_d           = rstate_q;
        rdata_d            = rdata_q;
        rresp_d            = rresp_q;
        case (rstate_q)
            R_IDLE: begin
                if (arvalid) begin
                    rstate_d = R_DATA;
                    case (araddr[3:2])
                        REG_TXDATA: begin rdata_d = '0;     rresp_d = RESP_OKAY;   end
                        REG_STATUS: begin rdata_d = status; rresp_d = RESP_OKAY;   end
                        default:    begin rdata_d = '0;     rresp_d = RESP_SLVERR; end
                    endcase
                end
            end
            R_DATA:  if (rready) rstate_d = R_IDLE;
            default: rstate_d = R_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wstate_q  <= W_IDLE;
            rstate_q  <= R_IDLE;
            aw_held_q <= 1'b0;
            aw_reg_q  <= '0;
            w_held_q  <= 1'b0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
            bresp_q   <= RESP_OKAY;
            rdata_q   <= '0;
            rresp_q   <= RESP_OKAY;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
        end else begin
            wstate_q  <= wstate_d;
            rstate_q  <= rstate_d;
            aw_held_q <= aw_held_d;
            aw_reg_q  <= aw_reg_d;
            w_held_q  <= w_held_d;
            wdata_q   <= wdata_d;
            wstrb_q   <= wstrb_d;
            bresp_q   <= bresp_d;
            rdata_q   <= rdata_d;
            rresp_q   <= rresp_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
        end
    end

    // Storage needs no reset: the count gates every read of it.
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= push_byte;
    end

    assign valid   = (count_q != '0);
    assign data    = valid ? mem_q[rd_ptr_q] : '0;
    assign awready = !aw_held_q;
    assign wready  = !w_held_q;
    assign bvalid  = (wstate_q == W_RESP);
    assign bresp   = bresp_q;
    assign arready = (rstate_q == R_IDLE);
    assign rvalid  = (rstate_q == R_DATA);
    assign rdata   = rdata_q;
    assign rresp   = rresp_q;
endmodule

// File: tb/tb_uart_tx_axi_fifo.sv
// Directed bench for uart_tx_axi_fifo; drained bytes are checked against a scoreboard queue.
module tb_uart_tx_axi_fifo;
    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic [7:0]  data;
    logic        valid;
    logic        ready = 1'b0;
    logic [31:0] awaddr = '0;
    logic        awvalid = 1'b0;
    logic        awready;
    logic [31:0] wdata = '0;
    logic [3:0]  wstrb = '0;
    logic        wvalid = 1'b0;
    logic        wready;
    logic        bvalid;
    logic        bready = 1'b0;
    logic [1:0]  bresp;
    logic [31:0] araddr = '0;
    logic        arvalid = 1'b0;
    logic        arready;
    logic [31:0] rdata;
    logic        rvalid;
    logic        rready = 1'b0;
    logic [1:0]  rresp;

    int n_checks = 0;
    int n_fail   = 0;
    logic [7:0] sb[$];

    uart_tx_axi_fifo #(.DATA_W(32), .FIFO_DEPTH(16), .ADDR_W(32)) dut (
        .clk(clk), .rstn(rstn), .data(data), .valid(valid), .ready(ready),
        .awaddr(awaddr), .awvalid(awvalid), .awready(awready),
        .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
        .bvalid(bvalid), .bready(bready), .bresp(bresp),
        .araddr(araddr), .arvalid(arvalid), .arready(arready),
        .rdata(rdata), .rvalid(rvalid), .rready(rready), .rresp(rresp)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // A byte leaves the FIFO at the posedge following a negedge with valid && ready.
    always @(negedge clk) begin
        if (rstn && valid && ready) begin
            if (sb.size() == 0) begin
                chk("unexpected_byte", {24'h0, data}, 32'hFFFF_FFFF);
            end else begin
                chk("drain_byte", {24'h0, data}, {24'h0, sb.pop_front()});
            end
        end
    end

    task automatic send_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                              input int w_lead);
        bit aw_pend, w_pend, hs_aw, hs_w;
        int n;
        awaddr = a; wdata = d; wstrb = s;
        aw_pend = 1'b1; w_pend = 1'b1;
        wvalid = 1'b1; awvalid = (w_lead == 0);
        n = 0;
        while ((aw_pend || w_pend) && n < 60) begin
            hs_aw = awvalid && awready;
            hs_w  = wvalid && wready;
            @(negedge clk); n++;
            if (hs_aw) begin aw_pend = 1'b0; awvalid = 1'b0; end
            if (hs_w)  begin w_pend  = 1'b0; wvalid  = 1'b0; end
            if (aw_pend && n >= w_lead) awvalid = 1'b1;
        end
        chk("aw_w_handshake_timeout", {30'h0, aw_pend, w_pend}, 32'h0);
        awvalid = 1'b0; wvalid = 1'b0;
    endtask

    task automatic wait_bresp(input logic [1:0] exp);
        int n = 0;
        bready = 1'b1;
        while (!bvalid && n < 200) begin @(negedge clk); n++; end
        chk("bvalid_seen", {31'h0, bvalid}, 32'h1);
        chk("bresp", {30'h0, bresp}, {30'h0, exp});
        @(negedge clk);
        bready = 1'b0;
        chk("bvalid_clear", {31'h0, bvalid}, 32'h0);
    endtask

    task automatic do_read(input logic [31:0] a, output logic [31:0] d, output logic [1:0] r);
        int n = 0;
        araddr = a; arvalid = 1'b1;
        while (!arready && n < 60) begin @(negedge clk); n++; end
        @(negedge clk);
        arvalid = 1'b0;
        chk("rvalid_latency", {31'h0, rvalid}, 32'h1);
        d = rdata; r = rresp;
        rready = 1'b1;
        @(negedge clk);
        rready = 1'b0;
        chk("rvalid_clear", {31'h0, rvalid}, 32'h0);
    endtask

    task automatic wait_drain();
        int n = 0;
        while (sb.size() != 0 && n < 300) begin @(negedge clk); n++; end
        @(negedge clk);
        chk("drain_left", sb.size(), 32'h0);
        chk("valid_after_drain", {31'h0, valid}, 32'h0);
    endtask

    initial begin
        logic [31:0] rd;
        logic [1:0]  rr;

        repeat (3) @(negedge clk);
        chk("rst_awready", {31'h0, awready}, 32'h1);
        chk("rst_wready",  {31'h0, wready},  32'h1);
        chk("rst_arready", {31'h0, arready}, 32'h1);
        chk("rst_valid",   {31'h0, valid},   32'h0);
        chk("rst_data",    {24'h0, data},    32'h0);
        chk("rst_bvalid",  {31'h0, bvalid},  32'h0);
        chk("rst_bresp",   {30'h0, bresp},   32'h0);
        chk("rst_rvalid",  {31'h0, rvalid},  32'h0);
        chk("rst_rdata",   rdata,            32'h0);
        chk("rst_rresp",   {30'h0, rresp},   32'h0);
        rstn = 1'b1;
        @(negedge clk);

        // Full-width write, ascending lanes
        ready = 1'b1;
        sb.push_back(8'h41); sb.push_back(8'h42); sb.push_back(8'h43); sb.push_back(8'h44);
        send_write(32'h0, 32'h4443_4241, 4'hF, 0);
        wait_bresp(2'b00);
        wait_drain();
        do_read(32'h4, rd, rr);
        chk("status_empty", rd, 32'h0001_0000);
        chk("status_rresp", {30'h0, rr}, 32'h0);
        do_read(32'h0, rd, rr);
        chk("txdata_rd", rd, 32'h0);
        chk("txdata_rresp", {30'h0, rr}, 32'h0);

        // W three cycles ahead of AW, sparse strobes
        sb.push_back(8'hCC); sb.push_back(8'hAA);
        send_write(32'h0, 32'hAABB_CCDD, 4'b1010, 3);
        wait_bresp(2'b00);
        wait_drain();

        // Unmapped, STATUS-targeted and empty-strobe writes push nothing
        send_write(32'h8, 32'h1122_3344, 4'hF, 0);
        wait_bresp(2'b10);
        send_write(32'h4, 32'h1122_3344, 4'hF, 0);
        wait_bresp(2'b10);
        send_write(32'h0, 32'h1122_3344, 4'h0, 1);
        wait_bresp(2'b00);
        do_read(32'hC, rd, rr);
        chk("unmapped_rdata", rd, 32'h0);
        chk("unmapped_rresp", {30'h0, rr}, 32'h2);
        do_read(32'h4, rd, rr);
        chk("status_no_push", rd, 32'h0001_0000);

        // 18 bytes against a 16-deep FIFO with the sink stalled
        ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            for (int b = 0; b < 4; b++) sb.push_back(8'(16 * i + b + 1));
            send_write(32'h0, {8'(16*i+4), 8'(16*i+3), 8'(16*i+2), 8'(16*i+1)}, 4'hF, 0);
            wait_bresp(2'b00);
        end
        sb.push_back(8'hE1); sb.push_back(8'hE2);
        send_write(32'h0, 32'h0000_E2E1, 4'b0011, 0);
        repeat (4) @(negedge clk);
        chk("stall_bvalid", {31'h0, bvalid}, 32'h0);
        do_read(32'h4, rd, rr);
        chk("status_full", rd, 32'h0006_0010);
        ready = 1'b1;
        wait_bresp(2'b00);
        wait_drain();

        // Fill, then release the sink while another write is unpacking
        ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            for (int b = 0; b < 4; b++) sb.push_back(8'(8'h80 + 4 * i + b));
            send_write(32'h0, {8'(8'h83+4*i), 8'(8'h82+4*i), 8'(8'h81+4*i), 8'(8'h80+4*i)},
                       4'hF, 0);
            wait_bresp(2'b00);
        end
        do_read(32'h4, rd, rr);
        chk("status_full2", rd, 32'h0002_0010);
        for (int b = 0; b < 4; b++) sb.push_back(8'(8'hF0 + b));
        ready = 1'b1;
        send_write(32'h0, 32'hF3F2_F1F0, 4'hF, 0);
        wait_bresp(2'b00);
        wait_drain();

        // Reset while unpacking with three bytes already queued
        ready = 1'b0;
        send_write(32'h0, 32'h5453_5251, 4'hF, 0);
        repeat (4) @(negedge clk);
        do_read(32'h4, rd, rr);
        chk("pre_reset_busy", {31'h0, rd[18]}, 32'h1);
        chk("pre_reset_valid", {31'h0, valid}, 32'h1);
        #2 rstn = 1'b0;
        #1;
        sb.delete();
        chk("mid_rst_valid",   {31'h0, valid},   32'h0);
        chk("mid_rst_data",    {24'h0, data},    32'h0);
        chk("mid_rst_bvalid",  {31'h0, bvalid},  32'h0);
        chk("mid_rst_awready", {31'h0, awready}, 32'h1);
        chk("mid_rst_wready",  {31'h0, wready},  32'h1);
        chk("mid_rst_arready", {31'h0, arready}, 32'h1);
        @(negedge clk);
        rstn = 1'b1;
        @(negedge clk);
        do_read(32'h4, rd, rr);
        chk("post_rst_status", rd, 32'h0001_0000);

        // Traffic resumes normally after reset
        ready = 1'b1;
        sb.push_back(8'h5A);
        send_write(32'h0, 32'h0000_005A, 4'b0001, 0);
        wait_bresp(2'b00);
        wait_drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
